// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register byte offsets and bus FSM states.
package gpio_pkg;

    localparam int NGPIO_MAX = 32;

    localparam int GPIO_DATA_IN  = 'h00;
    localparam int GPIO_DATA_OUT = 'h04;
    localparam int GPIO_DIR      = 'h08;
    localparam int GPIO_IRQ_EN   = 'h0C;
    localparam int GPIO_IRQ_TYPE = 'h10;
    localparam int GPIO_IRQ_POL  = 'h14;
    localparam int GPIO_IRQ_STAT = 'h18;
    localparam int GPIO_OUT_SET  = 'h1C;
    localparam int GPIO_OUT_CLR  = 'h20;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop input synchronizer with a history flop and edge detection.
// Edge outputs stay quiet until a short warm-up after reset has elapsed.
module gpio_sync_edge #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] s1_q, s2_q, prev_q;
    logic [1:0]       warm_q, warm_d;
    logic             warm_done;

    always_comb begin
        warm_done = (warm_q == 2'd3);
        warm_d    = warm_done ? warm_q : warm_q + 2'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            warm_q <= '0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            warm_q <= warm_d;
        end
    end

    // A pin sitting high at reset would otherwise look like a rising edge.
    assign sync_o = s2_q;
    assign rise_o = warm_done ? (s2_q & ~prev_q) : '0;
    assign fall_o = warm_done ? (~s2_q & prev_q) : '0;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: direction/output registers, synchronized read-back,
// per-pin edge/level interrupt status and a single level interrupt to the core.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int NGPIO  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ack_o,
    input  logic [NGPIO-1:0]  gpio_in_i,
    output logic [NGPIO-1:0]  gpio_out_o,
    output logic [NGPIO-1:0]  gpio_oe_o,
    output logic              irq_o
);

    bus_state_e           st_q, st_d;
    logic                 ack_q, ack_d;
    logic [NGPIO_MAX-1:0] rdata_q, rdata_d;
    logic [NGPIO-1:0]     data_out_q, data_out_d;
    logic [NGPIO-1:0]     dir_q, dir_d;
    logic [NGPIO-1:0]     irq_en_q, irq_en_d;
    logic [NGPIO-1:0]     irq_type_q, irq_type_d;
    logic [NGPIO-1:0]     irq_pol_q, irq_pol_d;
    logic [NGPIO-1:0]     irq_stat_q, irq_stat_d;

    logic [NGPIO-1:0]     sync, rise, fall;
    logic [NGPIO-1:0]     wmask, w1c, rd_val, edge_evt, lvl_evt, evt;
    logic [ADDR_W-1:0]    offset;
    logic                 access;
    logic                 unused_bus;

    gpio_sync_edge #(.WIDTH(NGPIO)) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (gpio_in_i),
        .sync_o (sync),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign unused_bus = ^{addr_i[1:0], wdata_i};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        access     = req_i && (st_q == ST_IDLE);
        offset     = {addr_i[ADDR_W-1:2], 2'b00};
        wmask      = wdata_i[NGPIO-1:0];
        rd_val     = '0;
        w1c        = '0;
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        irq_type_d = irq_type_q;
        irq_pol_d  = irq_pol_q;

        case (offset)
            ADDR_W'(GPIO_DATA_IN):  rd_val = sync;
            ADDR_W'(GPIO_DATA_OUT): rd_val = data_out_q;
            ADDR_W'(GPIO_DIR):      rd_val = dir_q;
            ADDR_W'(GPIO_IRQ_EN):   rd_val = irq_en_q;
            ADDR_W'(GPIO_IRQ_TYPE): rd_val = irq_type_q;
            ADDR_W'(GPIO_IRQ_POL):  rd_val = irq_pol_q;
            ADDR_W'(GPIO_IRQ_STAT): rd_val = irq_stat_q;
            default:                rd_val = '0;
        endcase

        if (access && we_i) begin
            case (offset)
                ADDR_W'(GPIO_DATA_OUT): data_out_d = wmask;
                ADDR_W'(GPIO_DIR):      dir_d      = wmask;
                ADDR_W'(GPIO_IRQ_EN):   irq_en_d   = wmask;
                ADDR_W'(GPIO_IRQ_TYPE): irq_type_d = wmask;
                ADDR_W'(GPIO_IRQ_POL):  irq_pol_d  = wmask;
                ADDR_W'(GPIO_IRQ_STAT): w1c        = wmask;
                ADDR_W'(GPIO_OUT_SET):  data_out_d = data_out_q | wmask;
                ADDR_W'(GPIO_OUT_CLR):  data_out_d = data_out_q & ~wmask;
                default:                ;
            endcase
        end

        // A new event wins over a same-cycle write-1-to-clear.
        edge_evt   = (irq_pol_q & rise) | (~irq_pol_q & fall);
        lvl_evt    = (irq_pol_q & sync) | (~irq_pol_q & ~sync);
        evt        = (irq_type_q & edge_evt) | (~irq_type_q & lvl_evt);
        irq_stat_d = (irq_stat_q & ~w1c) | evt;

        case (st_q)
            ST_IDLE: st_d = access ? ST_ACK : ST_IDLE;
            ST_ACK:  st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
        ack_d   = access;
        rdata_d = (access && !we_i) ? NGPIO_MAX'(rd_val) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q       <= ST_IDLE;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            data_out_q <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            irq_type_q <= '0;
            irq_pol_q  <= '0;
            irq_stat_q <= '0;
        end else begin
            st_q       <= st_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            irq_type_q <= irq_type_d;
            irq_pol_q  <= irq_pol_d;
            irq_stat_q <= irq_stat_d;
        end
    end

    assign rdata_o    = rdata_q;
    assign ack_o      = ack_q;
    assign gpio_out_o = data_out_q;
    assign gpio_oe_o  = dir_q;
    assign irq_o      = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios plus random bus/pin traffic
// compared every cycle against a pin-history based reference model.
module tb_gpio_ctrl;

    localparam int NG = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_i = 1'b0;
    logic          we_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [31:0]   wdata_i = '0;
    logic [31:0]   rdata_o;
    logic          ack_o;
    logic [NG-1:0] gpio_in_i = '0;
    logic [NG-1:0] gpio_out_o;
    logic [NG-1:0] gpio_oe_o;
    logic          irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [NG-1:0] m_out, m_dir, m_en, m_type, m_pol, m_stat;
    logic          m_ack, m_rd;
    logic [31:0]   m_rdata;
    logic [NG-1:0] hist[$];
    int            ecount;

    logic [NG-1:0] ack_out, ack_oe;
    logic [31:0]   rd;

    always #5 clk = ~clk;

    gpio_ctrl #(.NGPIO(NG), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .ack_o     (ack_o),
        .gpio_in_i (gpio_in_i),
        .gpio_out_o(gpio_out_o),
        .gpio_oe_o (gpio_oe_o),
        .irq_o     (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        m_out = '0; m_dir = '0; m_en = '0; m_type = '0; m_pol = '0; m_stat = '0;
        m_ack = 1'b0; m_rd = 1'b0; m_rdata = '0;
        hist.delete();
        ecount = 0;
    endfunction

    // Pin value sampled at clock edge e after reset release (0 before the first edge).
    function automatic logic [NG-1:0] pins_at(input int e);
        if (e >= 1 && e <= hist.size()) return hist[e-1];
        return '0;
    endfunction

    // One clock edge of the reference model, using the inputs present at that edge.
    task automatic model_step();
        logic [NG-1:0] cur, prv, rise, fall, ev, w1c, wd;
        logic [31:0]   rv;
        int            word;
        ecount++;
        hist.push_back(gpio_in_i);
        cur  = pins_at(ecount - 2);
        prv  = pins_at(ecount - 3);
        rise = (ecount >= 4) ? (cur & ~prv) : '0;
        fall = (ecount >= 4) ? (~cur & prv) : '0;
        for (int i = 0; i < NG; i++)
            ev[i] = m_type[i] ? (m_pol[i] ? rise[i] : fall[i]) : (m_pol[i] ? cur[i] : !cur[i]);
        w1c = '0;
        if (m_ack) begin
            m_ack = 1'b0; m_rd = 1'b0; m_rdata = '0;
        end else if (req_i) begin
            m_ack = 1'b1;
            m_rd  = !we_i;
            word  = int'(addr_i) & 'h3C;
            wd    = wdata_i[NG-1:0];
            case (word)
                'h00:    rv = 32'(cur);
                'h04:    rv = 32'(m_out);
                'h08:    rv = 32'(m_dir);
                'h0C:    rv = 32'(m_en);
                'h10:    rv = 32'(m_type);
                'h14:    rv = 32'(m_pol);
                'h18:    rv = 32'(m_stat);
                default: rv = '0;
            endcase
            m_rdata = we_i ? '0 : rv;
            if (we_i) begin
                case (word)
                    'h04: m_out  = wd;
                    'h08: m_dir  = wd;
                    'h0C: m_en   = wd;
                    'h10: m_type = wd;
                    'h14: m_pol  = wd;
                    'h18: w1c    = wd;
                    'h1C: m_out  = m_out | wd;
                    'h20: m_out  = m_out & ~wd;
                    default: ;
                endcase
            end
        end
        m_stat = (m_stat & ~w1c) | ev;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("ack", 32'(ack_o), 32'(m_ack));
        if (!m_ack || m_rd) check("rdata", rdata_o, m_rdata);
        check("gpio_out", 32'(gpio_out_o), 32'(m_out));
        check("gpio_oe", 32'(gpio_oe_o), 32'(m_dir));
        check("irq", 32'(irq_o), 32'(|(m_stat & m_en)));
    endtask

    task automatic bus(input logic w, input int addr, input logic [31:0] d, output logic [31:0] r);
        req_i = 1'b1; we_i = w; addr_i = AW'(addr); wdata_i = d;
        tick();
        r = rdata_o; ack_out = gpio_out_o; ack_oe = gpio_oe_o;
        req_i = 1'b0; we_i = 1'b0;
        tick();
    endtask

    task automatic enter_reset(input logic [NG-1:0] pins);
        reset_n = 1'b0; req_i = 1'b0; we_i = 1'b0; gpio_in_i = pins;
        model_clear();
        #1;
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_out", 32'(gpio_out_o), 32'd0);
        check("rst_oe", 32'(gpio_oe_o), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
    endtask

    task automatic leave_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int addrs[12] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h1C, 'h20, 'h24, 'h30, 'h3C};
    int cfg[6]    = '{'h04, 'h08, 'h0C, 'h10, 'h14, 'h1C};

    initial begin
        model_clear();
        @(negedge clk);
        enter_reset('0);
        leave_reset();

        // Reset readback of every register (model supplies expected values)
        for (int i = 0; i < 9; i++) bus(1'b0, i * 4, 32'h0, rd);
        check("reset_oe", 32'(gpio_oe_o), 32'h00);

        // Output path
        bus(1'b1, 'h08, 32'hF0, rd);  check("dir_oe", 32'(ack_oe), 32'hF0);
        bus(1'b1, 'h04, 32'hA5, rd);  check("dout_out", 32'(ack_out), 32'hA5);
        bus(1'b1, 'h1C, 32'h02, rd);  check("out_set", 32'(ack_out), 32'hA7);
        bus(1'b1, 'h20, 32'h81, rd);  check("out_clr", 32'(ack_out), 32'h26);

        // Rising-edge interrupt on pin 0
        bus(1'b1, 'h0C, 32'h01, rd);
        bus(1'b1, 'h10, 32'h01, rd);
        bus(1'b1, 'h14, 32'h01, rd);
        bus(1'b1, 'h18, 32'hFF, rd);
        gpio_in_i[0] = 1'b1;
        tick(); check("edge_k_irq", 32'(irq_o), 32'd0);
        tick(); check("edge_k1_irq", 32'(irq_o), 32'd0);
        tick(); check("edge_k2_irq", 32'(irq_o), 32'd1);
        bus(1'b0, 'h00, 32'h0, rd);   check("data_in0", 32'(rd[0]), 32'd1);
        bus(1'b0, 'h18, 32'h0, rd);   check("stat0_set", 32'(rd[0]), 32'd1);
        bus(1'b1, 'h18, 32'h01, rd);
        check("w1c_irq", 32'(irq_o), 32'd0);

        // Level-low on pin 3: W1C ineffective while the level persists
        bus(1'b1, 'h10, 32'h00, rd);
        bus(1'b1, 'h0C, 32'h08, rd);
        bus(1'b1, 'h18, 32'h08, rd);
        bus(1'b0, 'h18, 32'h0, rd);   check("lvl_sticky", 32'(rd[3]), 32'd1);
        check("lvl_irq", 32'(irq_o), 32'd1);
        gpio_in_i[3] = 1'b1;
        tick(); tick(); tick();
        bus(1'b1, 'h18, 32'h08, rd);
        bus(1'b0, 'h18, 32'h0, rd);   check("lvl_clear", 32'(rd[3]), 32'd0);
        check("lvl_irq_off", 32'(irq_o), 32'd0);

        // W1C coincident with a rising edge on pin 0: set wins
        bus(1'b1, 'h10, 32'h01, rd);
        gpio_in_i[0] = 1'b0;
        tick(); tick(); tick();
        bus(1'b1, 'h18, 32'h01, rd);
        bus(1'b0, 'h18, 32'h0, rd);   check("sc_pre_clear", 32'(rd[0]), 32'd0);
        gpio_in_i[0] = 1'b1;
        tick(); tick();
        bus(1'b1, 'h18, 32'h01, rd);
        bus(1'b0, 'h18, 32'h0, rd);   check("sc_set_wins", 32'(rd[0]), 32'd1);

        // Random traffic, including held requests, unmapped and misaligned addresses
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) gpio_in_i = gpio_in_i ^ (NG'(1) << $urandom_range(NG - 1));
            req_i   = ($urandom_range(2) != 0);
            we_i    = 1'($urandom_range(1));
            addr_i  = AW'(addrs[$urandom_range(11)] | int'($urandom_range(3)));
            wdata_i = $urandom;
            tick();
        end
        req_i = 1'b0; we_i = 1'b0;
        tick(); tick();

        // Reset asserted during an ACK cycle
        req_i = 1'b1; we_i = 1'b1; addr_i = AW'('h04); wdata_i = 32'hFF;
        tick();
        check("mid_ack_hi", 32'(ack_o), 32'd1);
        enter_reset(gpio_in_i);
        check("mid_ack_async", 32'(ack_o), 32'd0);
        leave_reset();
        for (int i = 0; i < 6; i++) begin
            bus(1'b0, cfg[i], 32'h0, rd);
            check("post_rst_reg", rd, 32'h0);
        end

        // Pins high through reset release with rising-edge interrupts enabled
        @(negedge clk);
        enter_reset('1);
        leave_reset();
        bus(1'b1, 'h0C, 32'hFF, rd);
        bus(1'b1, 'h14, 32'hFF, rd);
        bus(1'b1, 'h10, 32'hFF, rd);
        bus(1'b1, 'h18, 32'hFF, rd);
        for (int i = 0; i < 10; i++) tick();
        bus(1'b0, 'h18, 32'h0, rd);   check("warmup_stat", rd, 32'h0);
        check("warmup_irq", 32'(irq_o), 32'd0);
        bus(1'b0, 'h00, 32'h0, rd);   check("warmup_din", rd, 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
